// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory: fault codes, FSM states,
// the NOP instruction and the boot image used when IMEM_BOOT_ROM_EN is defined.
package imem_pkg;

   typedef enum logic [1:0] {
      IMEM_OK       = 2'b00,
      IMEM_MISALIGN = 2'b01,
      IMEM_OOR      = 2'b10
   } fault_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] boot_word(input logic [31:0] idx);
      logic [31:0] w;
      case (idx)
         32'd1:   w = 32'h0198_06B3;  // add
         32'd2:   w = 32'h4034_02B3;  // sub
         32'd3:   w = 32'h0031_70B3;  // and
         32'd7:   w = 32'h00F2_A403;  // lw
         32'd9:   w = 32'h00F2_A6A3;  // sw
         32'd11:  w = 32'h0094_8663;  // beq
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/imem_addr_chk.sv
// Byte-address decoder shared by fetch and program paths: word index plus fault code.
// Misalignment is reported ahead of out-of-range.
module imem_addr_chk
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 32,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic [1:0]        fault
);

   always_comb begin
      idx = addr[IDX_W+1:2];
      if (addr[1:0] != 2'b00)
         fault = IMEM_MISALIGN;
      else if (|addr[ADDR_W-1:IDX_W+2])
         fault = IMEM_OOR;
      else
         fault = IMEM_OK;
   end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with valid/ready fetch port, runtime program port and fault detection.
// After reset it sweeps every word; define IMEM_BOOT_ROM_EN to load the boot image instead of zeros.
module imem_fetch
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [1:0]        rsp_fault,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              init_done
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   state_e            state, state_nxt;
   logic [IDX_W-1:0]  cnt, cnt_nxt;

   logic [IDX_W-1:0]  req_idx, prog_idx;
   logic [1:0]        req_fault, prog_fault;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              accept;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   imem_addr_chk #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_req_chk (
      .addr  (req_addr),
      .idx   (req_idx),
      .fault (req_fault)
   );

   imem_addr_chk #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_prog_chk (
      .addr  (prog_addr),
      .idx   (prog_idx),
      .fault (prog_fault)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The single memory write port is owned by the sweep in INIT and by prog_en in RUN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      wr_idx    = prog_idx;
      wr_data   = prog_data;
      case (state)
         ST_INIT: begin
            wr_en   = 1'b1;
            wr_idx  = cnt;
`ifdef IMEM_BOOT_ROM_EN
            wr_data = DATA_W'(boot_word(32'(cnt)));
`else
            wr_data = '0;
`endif
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_IDX)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            wr_en = prog_en && (prog_fault == IMEM_OK);
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   assign init_done = (state == ST_RUN);
   assign req_ready = init_done && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;

   // The read samples mem before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_instr <= '0;
         rsp_fault <= IMEM_OK;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_fault <= req_fault;
         rsp_instr <= (req_fault == IMEM_OK) ? mem[req_idx] : DATA_W'(NOP);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: the driver pushes expected responses from a word-array
// model on every accepted request; a monitor compares each presented response to the queue head.
module tb_imem_fetch;

   localparam int DEPTH = 64;
   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_instr;
   logic [1:0]  rsp_fault;
   logic        prog_en = 1'b0;
   logic [31:0] prog_addr = '0;
   logic [31:0] prog_data = '0;
   logic        init_done;

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] q_instr [$];
   logic [1:0]  q_fault [$];

   imem_fetch #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_fault (rsp_fault),
      .prog_en   (prog_en),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`ifdef IMEM_BOOT_ROM_EN
      ref_mem[1]  = 32'h019806B3;
      ref_mem[2]  = 32'h403402B3;
      ref_mem[3]  = 32'h003170B3;
      ref_mem[7]  = 32'h00F2A403;
      ref_mem[9]  = 32'h00F2A6A3;
      ref_mem[11] = 32'h00948663;
`endif
   endtask

   function automatic logic addr_ok(input logic [31:0] a);
      return (a % 4 == 0) && (a < DEPTH * 4);
   endfunction

   // One clock cycle of stimulus, starting and ending at a negedge.
   task automatic cycle(input logic rv, input logic [31:0] ra, input logic pe,
                        input logic [31:0] pa, input logic [31:0] pd, input logic rr);
      req_valid = rv; req_addr = ra; prog_en = pe; prog_addr = pa; prog_data = pd;
      rsp_ready = rr;
      #1;
      if (rv && req_ready) begin
         if (ra % 4 != 0) begin
            q_instr.push_back(NOP_W); q_fault.push_back(2'b01);
         end else if (ra >= DEPTH * 4) begin
            q_instr.push_back(NOP_W); q_fault.push_back(2'b10);
         end else begin
            q_instr.push_back(ref_mem[ra / 4]); q_fault.push_back(2'b00);
         end
      end
      if (pe && init_done && addr_ok(pa)) ref_mem[pa / 4] = pd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, rr);
   endtask

   // Release reset at a negedge and time the sweep.
   task automatic release_and_sweep();
      int cycles;
      rst = 1'b1;
      cycles = 0;
      while (!init_done && cycles < 200) begin
         check("ready_low_in_init", {31'b0, req_ready}, 32'd0);
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      check("init_cycles", cycles, DEPTH);
      model_init();
   endtask

   task automatic reset_checks();
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_rsp_instr", rsp_instr, 32'd0);
      check("rst_rsp_fault", {30'b0, rsp_fault}, 32'd0);
      check("rst_init_done", {31'b0, init_done}, 32'd0);
   endtask

   // Monitor: compares every presented response against the queue head; pops on consume.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rsp_valid) begin
            if (q_instr.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected: got 0x%08h with nothing outstanding", rsp_instr);
            end else begin
               check("rsp_instr", rsp_instr, q_instr[0]);
               check("rsp_fault", {30'b0, rsp_fault}, {30'b0, q_fault[0]});
               if (rsp_ready) begin
                  void'(q_instr.pop_front());
                  void'(q_fault.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a, pa;
      int r;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks();
      release_and_sweep();

      // Boot image / zeroed words, then faults, then boundaries.
      cycle(1, 32'h04, 0, 0, 0, 1);
      cycle(1, 32'h08, 0, 0, 0, 1);
      cycle(1, 32'h0C, 0, 0, 0, 1);
      cycle(1, 32'h1C, 0, 0, 0, 1);
      cycle(1, 32'h24, 0, 0, 0, 1);
      cycle(1, 32'h2C, 0, 0, 0, 1);
      cycle(1, 32'h06, 0, 0, 0, 1);
      cycle(1, 32'h100, 0, 0, 0, 1);
      cycle(1, 32'h101, 0, 0, 0, 1);
      cycle(1, 32'hFC, 0, 0, 0, 1);
      cycle(1, 32'h8000_0004, 0, 0, 0, 1);
      cycle(1, 32'h04, 0, 0, 0, 1);

      // Same-word program and fetch: old word now, new word next cycle.
      cycle(1, 32'h10, 1, 32'h10, 32'hDEADBEEF, 1);
      cycle(1, 32'h10, 0, 0, 0, 1);
      // Faulting program writes are dropped.
      cycle(0, 0, 1, 32'h12, 32'h1111_1111, 1);
      cycle(0, 0, 1, 32'h110, 32'h2222_2222, 1);
      cycle(1, 32'h10, 0, 0, 0, 1);
      cycle(1, 32'h14, 0, 0, 0, 1);
      idle(2, 1);

      // Full-throughput stream: ready must stay high every cycle.
      for (int i = 0; i < 8; i++) begin
         req_valid = 1; req_addr = 32'(i * 4); rsp_ready = 1; #1;
         check("stream_req_ready", {31'b0, req_ready}, 32'd1);
         cycle(1, 32'(i * 4), 0, 0, 0, 1);
      end
      // Stream with rsp_ready toggling.
      for (int i = 0; i < 8; i++) cycle(1, 32'(4 * (i + 8)), 0, 0, 0, i[0]);
      idle(3, 1);
      check("stream_drained", q_instr.size(), 0);

      // Randomized mix of fetches, programs and back-pressure.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 65)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (r < 80) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else if (r < 90) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
         else             a = $urandom;
         pa = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
         cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0, pa, $urandom,
               $urandom_range(0, 3) != 0);
      end
      idle(3, 1);
      check("random_drained", q_instr.size(), 0);

      // Reset while a response is stalled.
      cycle(1, 32'h04, 0, 0, 0, 0);
      check("held_valid", {31'b0, rsp_valid}, 32'd1);
      #2 rst = 1'b0;
      #1 check("rst_clears_valid", {31'b0, rsp_valid}, 32'd0);
      q_instr.delete(); q_fault.delete();
      req_valid = 0; rsp_ready = 0;
      @(negedge clk);
      reset_checks();
      rst = 1'b1;
      repeat (20) @(negedge clk);
      // Reset mid-sweep, then a full rerun.
      rst = 1'b0;
      @(negedge clk);
      reset_checks();
      release_and_sweep();
      cycle(1, 32'h04, 0, 0, 0, 1);
      cycle(1, 32'h10, 0, 0, 0, 1);
      idle(3, 1);
      check("final_drained", q_instr.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a valid/ready fetch port, a runtime programming port and misaligned/out-of-range fault detection. It sits between the PC/fetch stage and the decoder. After reset it sweeps itself clean, or loads a boot image, before accepting fetches. Fetch responses are registered, with one-cycle latency and full throughput under back-pressure.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥ 16.
- ADDR_W, 32: byte-address width for fetch and program ports.
- DATA_W, 32: instruction width; fixed at 32 for RV32.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request can be accepted.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  response held in output register.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  DATA_W  fetched word; NOP 0x00000013 on fault.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- prog_en  in  1  write strobe.
- prog_addr  in  ADDR_W  write byte address, word-aligned.
- prog_data  in  DATA_W  word to write.
- init_done  out  1  high once the init sweep has finished.

## Operation
- FSM has two states: INIT and RUN. Reset forces INIT with the sweep counter at 0.
- INIT: each cycle writes word[cnt] with its init value and increments cnt. On cnt == DEPTH_WORDS-1 the block moves to RUN. INIT lasts exactly DEPTH_WORDS cycles.
- In INIT: req_ready = 0, prog_en is ignored (write dropped), init_done = 0.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Misaligned: addr[1:0] != 0. This has priority over out-of-range.
- Out of range: any address bit at or above log2(DEPTH_WORDS)+2 is set.
- A faulting request still completes a handshake. It returns rsp_instr = 0x00000013 with the matching rsp_fault, and the memory is not read.
- req_ready = RUN && (!rsp_valid || rsp_ready).
- A request is accepted when req_valid && req_ready.
- Programming: in RUN, a prog_en write with a misaligned or out-of-range prog_addr is dropped silently.
- If a fetch and a program write hit the same word in the same cycle, the fetch returns the old word (read-before-write).

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_instr 0, rsp_fault 00, init_done 0.
- Reset takes effect immediately. When rst deasserts, INIT starts on the next clock edge.
- Reset asserted mid-sweep or mid-response clears rsp_valid and restarts the sweep from 0.
- Fetch latency: a request accepted on edge N shows rsp_valid with its data after edge N.
- rsp_instr and rsp_fault stay stable while rsp_valid && !rsp_ready.
- Back-to-back accepts sustain one response per cycle while rsp_ready = 1.
- init_done rises on the edge that enters RUN. req_ready can first be 1 in that same cycle.
- Program writes are visible to fetches accepted one cycle or more later.

## Configuration
- IMEM_BOOT_ROM_EN defined: INIT loads the boot image. Word 1 = 0x019806B3 (add), word 2 = 0x403402B3 (sub), word 3 = 0x003170B3 (and), word 7 = 0x00F2A403 (lw), word 9 = 0x00F2A6A3 (sw), word 11 = 0x00948663 (beq). All other words are 0.
- IMEM_BOOT_ROM_EN undefined: INIT writes 0 to every word.

## Structure
- Shared package imem_pkg holds:
  - the fault-code enum (IMEM_OK, IMEM_MISALIGN, IMEM_OOR);
  - the FSM state enum;
  - the NOP constant 0x00000013;
  - the boot-image function returning the word for a given index.
- One sub-module, imem_addr_chk: combinational, shared by the fetch and program paths. Returns the word index and the fault code for a byte address.

## Test plan
- Reset release, IMEM_BOOT_ROM_EN undefined, DEPTH_WORDS = 64 -> init_done rises exactly 64 cycles after release; req_ready stays 0 until then; fetch of 0x04 returns 0x00000000, fault 00.
- IMEM_BOOT_ROM_EN defined -> fetches of 0x04, 0x08, 0x0C, 0x1C, 0x24, 0x2C return 0x019806B3, 0x403402B3, 0x003170B3, 0x00F2A403, 0x00F2A6A3, 0x00948663.
- Fetch 0x06 -> 0x00000013 with fault 01. Fetch 0x100 (DEPTH_WORDS = 64) -> 0x00000013 with fault 10. Memory contents unchanged in both cases.
- Program 0xDEADBEEF to 0x10 while fetching 0x10 in the same cycle -> old word returned. Fetch of 0x10 on the next cycle -> 0xDEADBEEF.
- Stream of 8 fetches with rsp_ready toggling 1/0 -> no response lost or duplicated; data stable while stalled; throughput is 1 per cycle when rsp_ready = 1.
- Assert rst mid-sweep and while rsp_valid = 1 -> rsp_valid clears immediately; full sweep reruns after release.
